input_buffer_lbdr: RTL and testbench

Per-input-port flit buffer and route computation for the 5-port mesh router. It sits directly upstream of the per-output arbiters. It accepts flits from the neighbouring router over the RTS/CTS handshake and stores them in a 4-entry FIFO. It decodes the head-of-packet destination with XY routing and drives one-hot `Req_N/E/W/S/L` into the arbiters, holding the request for the whole packet. It pops flits when any arbiter grants this input.

---
 rtl/noc_pkg.sv | 19 +
 rtl/input_buffer_lbdr_xy_route.sv | 39 +++
 rtl/input_buffer_lbdr.sv | 155 +++++++++++++++
 tb/tb_input_buffer_lbdr.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit type codes, route FSM states and
// the bit position of each direction in the one-hot request/grant vectors.
package noc_pkg;

   localparam logic [2:0] FLIT_HEADER = 3'b001;
   localparam logic [2:0] FLIT_BODY   = 3'b010;
   localparam logic [2:0] FLIT_TAIL   = 3'b100;

   typedef enum logic {IDLE, ROUTED} route_state_t;

   localparam int PORT_N     = 0;
   localparam int PORT_E     = 1;
   localparam int PORT_W     = 2;
   localparam int PORT_S     = 3;
   localparam int PORT_L     = 4;
   localparam int NUM_PORTS  = 5;
   localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/input_buffer_lbdr_xy_route.sv
// Combinational XY routing: resolve X first, then Y (y grows southward),
// and return a one-hot output direction indexed by the noc_pkg port constants.
module xy_route
   import noc_pkg::*;
#(
   parameter int ADDR_WIDTH   = 4,
   parameter int CUR_ADDR     = 0,
   parameter int NETWORK_COLS = 4
) (
   input  logic [ADDR_WIDTH-1:0] dest,
   output logic [NUM_PORTS-1:0]  dir
);

   localparam logic [ADDR_WIDTH-1:0] COLS = ADDR_WIDTH'(NETWORK_COLS);
   localparam logic [ADDR_WIDTH-1:0] CUR  = ADDR_WIDTH'(CUR_ADDR);
   localparam logic [ADDR_WIDTH-1:0] CX   = CUR % COLS;
   localparam logic [ADDR_WIDTH-1:0] CY   = CUR / COLS;

   logic [ADDR_WIDTH-1:0] dx;
   logic [ADDR_WIDTH-1:0] dy;

   assign dx = dest % COLS;
   assign dy = dest / COLS;

   always_comb begin
      dir = '0;
      if (dest == CUR)
         dir[PORT_L] = 1'b1;
      else if (dx > CX)
         dir[PORT_E] = 1'b1;
      else if (dx < CX)
         dir[PORT_W] = 1'b1;
      else if (dy < CY)
         dir[PORT_N] = 1'b1;
      else
         dir[PORT_S] = 1'b1;
   end

endmodule

// File: rtl/input_buffer_lbdr.sv
// Router input port: 4-entry RTS/CTS flit FIFO plus XY route request held per packet.
// Optional INPUT_PARITY_EN adds a sticky parity_err output (even parity over RX).
module input_buffer_lbdr
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 4,
   parameter int CUR_ADDR     = 0,
   parameter int NETWORK_COLS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  DRTS,
   input  logic [DATA_WIDTH-1:0] RX,
   output logic                  CTS,
   input  logic                  Grant_N,
   input  logic                  Grant_E,
   input  logic                  Grant_W,
   input  logic                  Grant_S,
   input  logic                  Grant_L,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  empty,
   output logic                  full,
   output logic                  Req_N,
   output logic                  Req_E,
   output logic                  Req_W,
   output logic                  Req_S,
   output logic                  Req_L
`ifdef INPUT_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   logic [DATA_WIDTH-1:0] mem_reg [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_sel [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] wr_ptr_reg;
   logic [FIFO_DEPTH-1:0] rd_ptr_reg;
   logic [2:0]            count_reg;
   logic                  cts_reg;
   logic [NUM_PORTS-1:0]  req_reg;
   logic [NUM_PORTS-1:0]  route_dir;
   route_state_t          state_reg;
   logic                  write_en;
   logic                  read_en;
   logic [2:0]            head_type;

   assign full     = (count_reg == 3'd4);
   assign empty    = (count_reg == 3'd0);
   assign write_en = DRTS & ~cts_reg & ~full;
   assign read_en  = (Grant_N | Grant_E | Grant_W | Grant_S | Grant_L) & ~empty;
   assign CTS      = cts_reg;

   // Storage is deliberately left unreset; count/pointers define what is valid.
   always_ff @(posedge clk) begin
      if (write_en) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_ptr_reg[i])
               mem_reg[i] <= RX;
         end
      end
   end

   // One-hot read pointer selects the head entry as an AND-OR mux.
   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_head_sel
         assign mem_sel[gi] = {DATA_WIDTH{rd_ptr_reg[gi]}} & mem_reg[gi];
      end
   endgenerate

   always_comb begin
      Data_out = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         Data_out = Data_out | mem_sel[i];
   end

   assign head_type = Data_out[DATA_WIDTH-1:DATA_WIDTH-3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cts_reg    <= 1'b0;
         wr_ptr_reg <= 4'b0001;
         rd_ptr_reg <= 4'b0001;
         count_reg  <= 3'd0;
      end else begin
         // A write acknowledges for exactly one cycle, pacing upstream at 2 cycles/flit.
         cts_reg <= write_en;
         if (write_en)
            wr_ptr_reg <= {wr_ptr_reg[FIFO_DEPTH-2:0], wr_ptr_reg[FIFO_DEPTH-1]};
         if (read_en)
            rd_ptr_reg <= {rd_ptr_reg[FIFO_DEPTH-2:0], rd_ptr_reg[FIFO_DEPTH-1]};
         case ({write_en, read_en})
            2'b10:   count_reg <= count_reg + 3'd1;
            2'b01:   count_reg <= count_reg - 3'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   xy_route #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .CUR_ADDR     (CUR_ADDR),
      .NETWORK_COLS (NETWORK_COLS)
   ) u_xy_route (
      .dest (Data_out[ADDR_WIDTH:1]),
      .dir  (route_dir)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         req_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!empty && head_type == FLIT_HEADER) begin
                  req_reg   <= route_dir;
                  state_reg <= ROUTED;
               end
            end
            ROUTED: begin
               if (read_en && head_type == FLIT_TAIL) begin
                  req_reg   <= '0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               req_reg   <= '0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign Req_N = req_reg[PORT_N];
   assign Req_E = req_reg[PORT_E];
   assign Req_W = req_reg[PORT_W];
   assign Req_S = req_reg[PORT_S];
   assign Req_L = req_reg[PORT_L];

`ifdef INPUT_PARITY_EN
   logic parity_err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_err_reg <= 1'b0;
      else if (write_en && (^RX))
         parity_err_reg <= 1'b1;
   end

   assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_input_buffer_lbdr.sv
// Directed bench for input_buffer_lbdr at CUR_ADDR=5 (x=1,y=1) in a 4-column mesh.
// Parity checks are included when INPUT_PARITY_EN is defined.
module tb_input_buffer_lbdr;

   localparam logic [2:0] T_HDR  = 3'b001;
   localparam logic [2:0] T_BODY = 3'b010;
   localparam logic [2:0] T_TAIL = 3'b100;
   // request/grant vectors packed as {N,E,W,S,L}
   localparam logic [4:0] RN = 5'b10000;
   localparam logic [4:0] RE = 5'b01000;
   localparam logic [4:0] RW = 5'b00100;
   localparam logic [4:0] RS = 5'b00010;
   localparam logic [4:0] RL = 5'b00001;

   logic        clk = 1'b0;
   logic        rst;
   logic        DRTS;
   logic [31:0] RX;
   logic        CTS;
   logic        Grant_N, Grant_E, Grant_W, Grant_S, Grant_L;
   logic [31:0] Data_out;
   logic        empty, full;
   logic        Req_N, Req_E, Req_W, Req_S, Req_L;
`ifdef INPUT_PARITY_EN
   logic        parity_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] req_v;
   assign req_v = {Req_N, Req_E, Req_W, Req_S, Req_L};

   input_buffer_lbdr #(
      .DATA_WIDTH   (32),
      .ADDR_WIDTH   (4),
      .CUR_ADDR     (5),
      .NETWORK_COLS (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .DRTS     (DRTS),
      .RX       (RX),
      .CTS      (CTS),
      .Grant_N  (Grant_N),
      .Grant_E  (Grant_E),
      .Grant_W  (Grant_W),
      .Grant_S  (Grant_S),
      .Grant_L  (Grant_L),
      .Data_out (Data_out),
      .empty    (empty),
      .full     (full),
      .Req_N    (Req_N),
      .Req_E    (Req_E),
      .Req_W    (Req_W),
      .Req_S    (Req_S),
      .Req_L    (Req_L)
`ifdef INPUT_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkflit(input logic [2:0] t, input logic [3:0] dest,
                                          input logic [23:0] pay);
      logic [31:0] f;
      f    = {t, pay, dest, 1'b0};
      f[0] = ^f[31:1];
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_grant(input logic [4:0] g);
      {Grant_N, Grant_E, Grant_W, Grant_S, Grant_L} = g;
   endtask

   task automatic pop(input logic [4:0] g);
      set_grant(g);
      tick();
      set_grant(5'b0);
   endtask

   // Present a flit and hold DRTS until CTS is seen, within a cycle budget.
   task automatic write_flit(input logic [31:0] d, input string tag);
      logic done;
      done = 1'b0;
      DRTS = 1'b1;
      RX   = d;
      for (int i = 0; i < 8 && !done; i++) begin
         tick();
         if (CTS)
            done = 1'b1;
      end
      DRTS = 1'b0;
      check({tag, "_cts_seen"}, {31'b0, done}, 32'd1);
   endtask

   logic [31:0] h7, b7, hL, bL, tL, hF, b1, b2, b3, tF, hS, bS, tS, hx, tx;
   logic [3:0]  xy_dest [4];
   logic [4:0]  xy_exp  [4];

   initial begin
      rst  = 1'b1;
      DRTS = 1'b0;
      RX   = '0;
      set_grant(5'b0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_cts",   {31'b0, CTS},   32'd0);
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_full",  {31'b0, full},  32'd0);
      check("rst_req",   {27'b0, req_v}, 32'd0);

      // Header dest 7, then async reset mid-packet while CTS is high
      h7 = mkflit(T_HDR, 4'd7, 24'h0000A1);
      b7 = mkflit(T_BODY, 4'd0, 24'h0000A2);
      write_flit(h7, "pre_h7");
      check("pre_head", Data_out, h7);
      tick();
      check("pre_req_e", {27'b0, req_v}, {27'b0, RE});
      DRTS = 1'b1;
      RX   = b7;
      tick();
      DRTS = 1'b0;
      check("pre_cts_high", {31'b0, CTS}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_cts",   {31'b0, CTS},   32'd0);
      check("async_rst_empty", {31'b0, empty}, 32'd1);
      check("async_rst_full",  {31'b0, full},  32'd0);
      check("async_rst_req",   {27'b0, req_v}, 32'd0);
      #2 rst = 1'b0;
      tick();

      // Local packet: header/body/tail to dest 5
      hL = mkflit(T_HDR, 4'd5, 24'h00C001);
      bL = mkflit(T_BODY, 4'd9, 24'h00B0B0);
      tL = mkflit(T_TAIL, 4'd3, 24'h00DEAD);
      write_flit(hL, "loc_h");
      check("loc_head", Data_out, hL);
      check("loc_req_before", {27'b0, req_v}, 32'd0);
      write_flit(bL, "loc_b");
      write_flit(tL, "loc_t");
      check("loc_req_l", {27'b0, req_v}, {27'b0, RL});
      set_grant(RL);
      tick();
      check("loc_pop1_data", Data_out, bL);
      tick();
      check("loc_pop2_data", Data_out, tL);
      check("loc_req_held", {27'b0, req_v}, {27'b0, RL});
      tick();
      set_grant(5'b0);
      check("loc_req_cleared", {27'b0, req_v}, 32'd0);
      check("loc_empty", {31'b0, empty}, 32'd1);

      // XY routing from (1,1): 7->E, 4->W, 1->N, 13->S
      xy_dest[0] = 4'd7;  xy_exp[0] = RE;
      xy_dest[1] = 4'd4;  xy_exp[1] = RW;
      xy_dest[2] = 4'd1;  xy_exp[2] = RN;
      xy_dest[3] = 4'd13; xy_exp[3] = RS;
      for (int k = 0; k < 4; k++) begin
         hx = mkflit(T_HDR, xy_dest[k], 24'(k + 16));
         tx = mkflit(T_TAIL, 4'd0, 24'(k + 32));
         write_flit(hx, $sformatf("xy%0d_h", k));
         write_flit(tx, $sformatf("xy%0d_t", k));
         check($sformatf("xy_dest%0d_req", xy_dest[k]), {27'b0, req_v}, {27'b0, xy_exp[k]});
         pop(xy_exp[k]);
         check($sformatf("xy_dest%0d_tail", xy_dest[k]), Data_out, tx);
         pop(xy_exp[k]);
         check($sformatf("xy_dest%0d_clear", xy_dest[k]), {27'b0, req_v}, 32'd0);
      end

      // Full: four flits, a fifth is held off until one grant frees a slot
      hF = mkflit(T_HDR, 4'd7, 24'h000F00);
      b1 = mkflit(T_BODY, 4'd1, 24'h000F01);
      b2 = mkflit(T_BODY, 4'd2, 24'h000F02);
      b3 = mkflit(T_BODY, 4'd3, 24'h000F03);
      tF = mkflit(T_TAIL, 4'd4, 24'h000F04);
      write_flit(hF, "full_h");
      write_flit(b1, "full_b1");
      write_flit(b2, "full_b2");
      write_flit(b3, "full_b3");
      check("full_set", {31'b0, full}, 32'd1);
      DRTS = 1'b1;
      RX   = tF;
      tick();
      tick();
      tick();
      check("full_no_cts", {31'b0, CTS}, 32'd0);
      set_grant(RE);
      tick();
      set_grant(5'b0);
      check("full_blocked_during_read", {31'b0, CTS}, 32'd0);
      check("full_after_read", {31'b0, full}, 32'd0);
      check("full_pop_data", Data_out, b1);
      tick();
      DRTS = 1'b0;
      check("full_fifth_cts", {31'b0, CTS}, 32'd1);
      check("full_refilled", {31'b0, full}, 32'd1);
      pop(RE);
      check("drain_b2", Data_out, b2);
      pop(RE);
      check("drain_b3", Data_out, b3);
      pop(RE);
      check("drain_tail", Data_out, tF);
      pop(RE);
      check("drain_empty", {31'b0, empty}, 32'd1);
      check("drain_req_clear", {27'b0, req_v}, 32'd0);

      // Simultaneous write and read at count 2
      hS = mkflit(T_HDR, 4'd7, 24'h005501);
      bS = mkflit(T_BODY, 4'd0, 24'h005502);
      tS = mkflit(T_TAIL, 4'd0, 24'h005503);
      write_flit(hS, "sim_h");
      write_flit(bS, "sim_b");
      tick();
      check("sim_req_e", {27'b0, req_v}, {27'b0, RE});
      DRTS = 1'b1;
      RX   = tS;
      set_grant(RE);
      tick();
      DRTS = 1'b0;
      set_grant(5'b0);
      check("sim_cts", {31'b0, CTS}, 32'd1);
      check("sim_data_adv", Data_out, bS);
      check("sim_not_full", {31'b0, full}, 32'd0);
      pop(RE);
      check("sim_second", Data_out, tS);
      check("sim_not_empty", {31'b0, empty}, 32'd0);
      pop(RE);
      check("sim_empty", {31'b0, empty}, 32'd1);
      check("sim_req_clear", {27'b0, req_v}, 32'd0);

`ifdef INPUT_PARITY_EN
      // Parity: sticky error after a corrupted flit, cleared only by reset
      check("par_clean", {31'b0, parity_err}, 32'd0);
      write_flit(mkflit(T_BODY, 4'd0, 24'h00AAAA) ^ 32'h0000_0100, "par_bad");
      check("par_set", {31'b0, parity_err}, 32'd1);
      write_flit(mkflit(T_BODY, 4'd0, 24'h00BBBB), "par_good");
      tick();
      check("par_sticky", {31'b0, parity_err}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("par_rst_clear", {31'b0, parity_err}, 32'd0);
      #2 rst = 1'b0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
